// File: rtl/p2m_echo_indication_pkg.sv
// p2m_echo_indication_pkg: method ids, message lengths and header layout shared by the Echo marshaller and demarshaller
package p2m_echo_indication_pkg;
    localparam int MSG_W       = 128;
    localparam int LEN_W       = 16;
    localparam int HDR_FIELD_W = 16;
    localparam int PORTAL_LSB  = 0;
    localparam int METHOD_LSB  = 16;

    localparam logic [HDR_FIELD_W-1:0] HEARD2_ID = 16'd0;
    localparam logic [HDR_FIELD_W-1:0] HEARD3_ID = 16'd1;
    localparam logic [HDR_FIELD_W-1:0] HEARD_ID  = 16'd2;

    localparam logic [LEN_W-1:0] HEARD2_LEN = 16'd2;
    localparam logic [LEN_W-1:0] HEARD3_LEN = 16'd4;
    localparam logic [LEN_W-1:0] HEARD_LEN  = 16'd2;

    // Length in words (header included) a method id requires; unknown ids map to 0.
    function automatic logic [LEN_W-1:0] method_len(input logic [HDR_FIELD_W-1:0] id);
        return id == HEARD2_ID ? HEARD2_LEN :
               id == HEARD3_ID ? HEARD3_LEN :
               id == HEARD_ID  ? HEARD_LEN  : '0;
    endfunction
endpackage

// File: rtl/p2m_echo_indication_if.sv
// p2m_echo_indication_if: pipe enqueue handshake plus the heard/heard2/heard3 method call handshakes
//   master: drives the pipe message and the method sink RDYs (host harness side)
//   slave : the demarshaller; drives pipe RDY and the method ENAs/arguments
interface p2m_echo_indication_if;
    import p2m_echo_indication_pkg::*;
    logic                enq_ena;
    logic [MSG_W-1:0]    enq_v;
    logic [LEN_W-1:0]    enq_length;
    logic                enq_rdy;
    logic                heard_ena;
    logic [31:0]         heard_v;
    logic                heard_rdy;
    logic                heard2_ena;
    logic [15:0]         heard2_a;
    logic [15:0]         heard2_b;
    logic                heard2_rdy;
    logic                heard3_ena;
    logic [15:0]         heard3_a;
    logic [31:0]         heard3_b;
    logic [31:0]         heard3_c;
    logic [15:0]         heard3_d;
    logic                heard3_rdy;

    modport master (
        output enq_ena, enq_v, enq_length, heard_rdy, heard2_rdy, heard3_rdy,
        input  enq_rdy, heard_ena, heard_v, heard2_ena, heard2_a, heard2_b,
               heard3_ena, heard3_a, heard3_b, heard3_c, heard3_d
    );

    modport slave (
        input  enq_ena, enq_v, enq_length, heard_rdy, heard2_rdy, heard3_rdy,
        output enq_rdy, heard_ena, heard_v, heard2_ena, heard2_a, heard2_b,
               heard3_ena, heard3_a, heard3_b, heard3_c, heard3_d
    );
endinterface

// File: rtl/p2m_msg_buffer.sv
// p2m_msg_buffer: one-entry message buffer that can retire and refill in the same cycle
//   CLK, nRST : clock, asynchronous active-low reset
//   enq_ena   : enqueue request, honoured only while enq_rdy
//   enq_data  : message to hold
//   retire    : consumer is done with the held entry this cycle
//   enq_rdy   : empty, or being emptied this cycle
//   valid/data: held entry
module p2m_msg_buffer #(
    parameter int W = 144
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         enq_ena,
    input  logic [W-1:0] enq_data,
    input  logic         retire,
    output logic         enq_rdy,
    output logic         valid,
    output logic [W-1:0] data
);
    logic accept;

    assign enq_rdy = !valid || retire;
    assign accept  = enq_ena && enq_rdy;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            valid <= accept || (valid && !retire);
            if (accept) data <= enq_data;
        end
    end
endmodule

// File: rtl/p2m_echo_indication.sv
// p2m_echo_indication: Echo indication demarshaller turning one 128-bit pipe message into a heard/heard2/heard3 call
//   CLK, nRST  : clock, asynchronous active-low reset
//   io         : pipe enqueue and method call handshakes (slave side)
//   drop       : one-cycle pulse when a held message is malformed and discarded
//   drop_count : saturating count of discarded messages
module p2m_echo_indication
    import p2m_echo_indication_pkg::*;
#(
    parameter logic [HDR_FIELD_W-1:0] PORTAL_ID = 16'd5,
    parameter int                     ERR_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 nRST,
    p2m_echo_indication_if.slave io,
    output logic                 drop,
    output logic [ERR_WIDTH-1:0] drop_count
);
    logic                   valid;
    logic                   retire;
    logic                   good;
    logic                   bad;
    logic [MSG_W+LEN_W-1:0] held;
    logic [MSG_W-1:0]       msg;
    logic [LEN_W-1:0]       len;
    logic [HDR_FIELD_W-1:0] portal;
    logic [HDR_FIELD_W-1:0] id;

    p2m_msg_buffer #(.W(MSG_W + LEN_W)) u_buf (
        .CLK      (CLK),
        .nRST     (nRST),
        .enq_ena  (io.enq_ena),
        .enq_data ({io.enq_length, io.enq_v}),
        .retire   (retire),
        .enq_rdy  (io.enq_rdy),
        .valid    (valid),
        .data     (held)
    );

    assign {len, msg} = held;

    always_comb begin
        portal = msg[PORTAL_LSB +: HDR_FIELD_W];
        id     = msg[METHOD_LSB +: HDR_FIELD_W];
        // The explicit id range test matters: unknown ids map to length 0, which a zero-length message would match.
        good   = valid && portal == PORTAL_ID && id <= HEARD_ID && len == method_len(id);
        bad    = valid && !good;
        io.heard2_ena = good && id == HEARD2_ID && io.heard2_rdy;
        io.heard3_ena = good && id == HEARD3_ID && io.heard3_rdy;
        io.heard_ena  = good && id == HEARD_ID  && io.heard_rdy;
        io.heard2_a   = io.heard2_ena ? msg[47:32]   : '0;
        io.heard2_b   = io.heard2_ena ? msg[63:48]   : '0;
        io.heard3_a   = io.heard3_ena ? msg[47:32]   : '0;
        io.heard3_b   = io.heard3_ena ? msg[79:48]   : '0;
        io.heard3_c   = io.heard3_ena ? msg[111:80]  : '0;
        io.heard3_d   = io.heard3_ena ? msg[127:112] : '0;
        io.heard_v    = io.heard_ena  ? msg[63:32]   : '0;
        retire = io.heard_ena || io.heard2_ena || io.heard3_ena || bad;
        drop   = bad;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) drop_count <= '0;
        else if (bad && !(&drop_count)) drop_count <= drop_count + 1'b1;
    end
endmodule

// File: tb/tb_p2m_echo_indication.sv
// tb_p2m_echo_indication: scoreboard bench for the Echo indication demarshaller
module tb_p2m_echo_indication;
    typedef struct packed {
        logic        h_ena;
        logic [31:0] hv;
        logic        h2_ena;
        logic [15:0] h2a;
        logic [15:0] h2b;
        logic        h3_ena;
        logic [15:0] h3a;
        logic [31:0] h3b;
        logic [31:0] h3c;
        logic [15:0] h3d;
        logic        drop;
    } obs_t;

    logic       clk;
    logic       rst_n;
    logic       drop;
    logic [7:0] drop_count;
    int         checks;
    int         fails;
    obs_t       sb[$];

    p2m_echo_indication_if io();

    p2m_echo_indication #(.PORTAL_ID(16'd5), .ERR_WIDTH(8)) dut (
        .CLK        (clk),
        .nRST       (rst_n),
        .io         (io),
        .drop       (drop),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    function automatic obs_t exp_heard(input logic [31:0] v);
        obs_t e = '0;
        e.h_ena = 1'b1;
        e.hv    = v;
        return e;
    endfunction

    function automatic obs_t exp_heard2(input logic [15:0] a, input logic [15:0] b);
        obs_t e = '0;
        e.h2_ena = 1'b1;
        e.h2a    = a;
        e.h2b    = b;
        return e;
    endfunction

    function automatic obs_t exp_heard3(input logic [15:0] a, input logic [31:0] b, input logic [31:0] c, input logic [15:0] d);
        obs_t e = '0;
        e.h3_ena = 1'b1;
        e.h3a    = a;
        e.h3b    = b;
        e.h3c    = c;
        e.h3d    = d;
        return e;
    endfunction

    function automatic obs_t exp_drop();
        obs_t e = '0;
        e.drop = 1'b1;
        return e;
    endfunction

    // Scoreboard monitor: every cycle with a method call or drop consumes one expected entry.
    always @(negedge clk) begin
        obs_t g;
        obs_t e;
        g.h_ena  = io.heard_ena;
        g.hv     = io.heard_v;
        g.h2_ena = io.heard2_ena;
        g.h2a    = io.heard2_a;
        g.h2b    = io.heard2_b;
        g.h3_ena = io.heard3_ena;
        g.h3a    = io.heard3_a;
        g.h3b    = io.heard3_b;
        g.h3c    = io.heard3_c;
        g.h3d    = io.heard3_d;
        g.drop   = drop;
        if (g.h_ena || g.h2_ena || g.h3_ena || g.drop) begin
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected got=%h expected no event", g);
            end else begin
                e = sb.pop_front();
                if (g !== e) begin
                    fails++;
                    $display("FAIL sb_event got=%h expected=%h", g, e);
                end
            end
        end
    end

    // Presents one message until accepted; returns the number of cycles it had to wait.
    task automatic send(input logic [127:0] v, input logic [15:0] len, input obs_t e, output int waited);
        waited = 0;
        io.enq_v      = v;
        io.enq_length = len;
        io.enq_ena    = 1'b1;
        while (!io.enq_rdy && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!io.enq_rdy) begin
            checks++;
            fails++;
            $display("FAIL send_timeout enq_rdy=%b expected 1 within 20 cycles", io.enq_rdy);
            io.enq_ena = 1'b0;
            return;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        io.enq_ena = 1'b0;
    endtask

    task automatic drain(output bit ok);
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = sb.size() == 0;
    endtask

    task automatic test_reset();
        io.heard_rdy  = 1'b1;
        io.heard2_rdy = 1'b1;
        io.heard3_rdy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (io.enq_rdy !== 1'b1) begin fails++; $display("FAIL reset_rdy got=%b expected 1", io.enq_rdy); end
        checks++;
        if ({io.heard_ena, io.heard2_ena, io.heard3_ena, drop} !== 4'b0) begin
            fails++;
            $display("FAIL reset_ena got=%b expected 0000", {io.heard_ena, io.heard2_ena, io.heard3_ena, drop});
        end
        checks++;
        if (drop_count !== 8'd0) begin fails++; $display("FAIL reset_drop_count got=%0d expected 0", drop_count); end
        checks++;
        if ({io.heard_v, io.heard2_a, io.heard2_b, io.heard3_a, io.heard3_b, io.heard3_c, io.heard3_d} !== '0) begin
            fails++;
            $display("FAIL reset_data got=%h expected 0", {io.heard_v, io.heard2_a, io.heard2_b, io.heard3_a, io.heard3_b, io.heard3_c, io.heard3_d});
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_heard();
        int w;
        bit ok;
        send({32'h0, 32'hDEADBEEF, 16'd2, 16'd5}, 16'd2, exp_heard(32'hDEADBEEF), w);
        @(negedge clk);
        checks++;
        if (io.heard_ena !== 1'b1 || io.heard_v !== 32'hDEADBEEF || io.heard2_ena !== 1'b0 || io.heard3_ena !== 1'b0 || drop !== 1'b0) begin
            fails++;
            $display("FAIL heard_latency got ena=%b v=%h h2=%b h3=%b drop=%b expected 1 deadbeef 0 0 0",
                     io.heard_ena, io.heard_v, io.heard2_ena, io.heard3_ena, drop);
        end
        drain(ok);
        checks++;
        if (!ok) begin fails++; $display("FAIL heard_drain pending=%0d expected 0", sb.size()); end
    endtask

    task automatic test_backpressure();
        int w;
        bit ok;
        io.heard2_rdy = 1'b0;
        send({64'h0, 16'hABCD, 16'h1234, 16'd0, 16'd5}, 16'd2, exp_heard2(16'h1234, 16'hABCD), w);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (io.heard2_ena !== 1'b0 || io.enq_rdy !== 1'b0 || io.heard2_a !== 16'h0 || io.heard2_b !== 16'h0) begin
                fails++;
                $display("FAIL bp_blocked cycle %0d got ena=%b rdy=%b a=%h b=%h expected 0 0 0 0",
                         i, io.heard2_ena, io.enq_rdy, io.heard2_a, io.heard2_b);
            end
        end
        @(posedge clk);
        #1;
        io.heard2_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (io.heard2_ena !== 1'b1 || io.heard2_a !== 16'h1234 || io.heard2_b !== 16'hABCD || io.enq_rdy !== 1'b1) begin
            fails++;
            $display("FAIL bp_release got ena=%b a=%h b=%h rdy=%b expected 1 1234 abcd 1",
                     io.heard2_ena, io.heard2_a, io.heard2_b, io.enq_rdy);
        end
        drain(ok);
        checks++;
        if (!ok) begin fails++; $display("FAIL bp_drain pending=%0d expected 0", sb.size()); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        fork
            for (int i = 0; i < 4; i++) begin
                int w;
                logic [31:0] c;
                c = 32'h3 + i;
                send({16'h4, c, 32'h2, 16'h1, 16'd1, 16'd5}, 16'd4, exp_heard3(16'h1, 32'h2, c, 16'h4), w);
                checks++;
                if (w != 0) begin fails++; $display("FAIL b2b_rdy msg %0d waited=%0d expected 0", i, w); end
            end
            begin
                @(posedge clk);
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    checks++;
                    if (io.heard3_ena !== 1'b1 || io.heard3_c !== 32'h3 + k) begin
                        fails++;
                        $display("FAIL b2b_ena msg %0d got ena=%b c=%h expected 1 %h", k, io.heard3_ena, io.heard3_c, 32'h3 + k);
                    end
                end
            end
        join
        drain(ok);
        checks++;
        if (!ok) begin fails++; $display("FAIL b2b_drain pending=%0d expected 0", sb.size()); end
    endtask

    task automatic test_bad();
        logic [127:0] msgs [3];
        logic [15:0]  lens [3];
        msgs[0] = {32'h0, 32'h11111111, 16'd2, 16'd6};
        lens[0] = 16'd2;
        msgs[1] = {32'h0, 32'h22222222, 16'd3, 16'd5};
        lens[1] = 16'd2;
        msgs[2] = {32'h0, 32'h33333333, 16'd2, 16'd5};
        lens[2] = 16'd4;
        for (int i = 0; i < 3; i++) begin
            int w;
            bit ok;
            send(msgs[i], lens[i], exp_drop(), w);
            @(negedge clk);
            checks++;
            if (drop !== 1'b1 || {io.heard_ena, io.heard2_ena, io.heard3_ena} !== 3'b0) begin
                fails++;
                $display("FAIL bad_pulse case %0d got drop=%b ena=%b expected 1 000", i, drop, {io.heard_ena, io.heard2_ena, io.heard3_ena});
            end
            @(negedge clk);
            checks++;
            if (drop !== 1'b0) begin fails++; $display("FAIL bad_pulse_width case %0d got drop=%b expected 0", i, drop); end
            drain(ok);
            checks++;
            if (drop_count !== 8'(i + 1)) begin fails++; $display("FAIL bad_count case %0d got=%0d expected %0d", i, drop_count, i + 1); end
        end
    endtask

    task automatic test_saturate();
        int w;
        bit ok;
        for (int i = 0; i < 251; i++) send({96'h0, 16'd2, 16'd0}, 16'd2, exp_drop(), w);
        drain(ok);
        @(negedge clk);
        checks++;
        if (drop_count !== 8'd254) begin fails++; $display("FAIL sat_pre got=%0d expected 254", drop_count); end
        for (int i = 0; i < 46; i++) send({96'h0, 16'd2, 16'd0}, 16'd2, exp_drop(), w);
        drain(ok);
        @(negedge clk);
        checks++;
        if (drop_count !== 8'd255) begin fails++; $display("FAIL sat_300 got=%0d expected 255", drop_count); end
        send({96'h0, 16'd2, 16'd0}, 16'd2, exp_drop(), w);
        drain(ok);
        @(negedge clk);
        checks++;
        if (drop_count !== 8'd255) begin fails++; $display("FAIL sat_hold got=%0d expected 255", drop_count); end
    endtask

    task automatic test_async_reset();
        int w;
        bit ok;
        io.heard_rdy = 1'b0;
        send({32'h0, 32'h55AA55AA, 16'd2, 16'd5}, 16'd2, exp_heard(32'h55AA55AA), w);
        @(negedge clk);
        checks++;
        if (io.heard_ena !== 1'b0 || io.enq_rdy !== 1'b0) begin
            fails++;
            $display("FAIL arst_blocked got ena=%b rdy=%b expected 0 0", io.heard_ena, io.enq_rdy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (io.enq_rdy !== 1'b1 || drop_count !== 8'd0 || {io.heard_ena, io.heard2_ena, io.heard3_ena, drop} !== 4'b0 || io.heard_v !== 32'h0) begin
            fails++;
            $display("FAIL arst_immediate got rdy=%b count=%0d ena=%b v=%h expected 1 0 0000 0",
                     io.enq_rdy, drop_count, {io.heard_ena, io.heard2_ena, io.heard3_ena, drop}, io.heard_v);
        end
        sb.delete();
        @(posedge clk);
        #1;
        io.heard_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (io.heard_ena !== 1'b0) begin fails++; $display("FAIL arst_in_reset got ena=%b expected 0", io.heard_ena); end
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (io.heard_ena !== 1'b0 || drop !== 1'b0) begin
                fails++;
                $display("FAIL arst_stale cycle %0d got ena=%b drop=%b expected 0 0", i, io.heard_ena, drop);
            end
        end
        @(posedge clk);
        #1;
        send({32'h0, 32'hC0FFEE00, 16'd2, 16'd5}, 16'd2, exp_heard(32'hC0FFEE00), w);
        drain(ok);
        checks++;
        if (!ok) begin fails++; $display("FAIL arst_recover pending=%0d expected 0", sb.size()); end
    endtask

    initial begin
        clk           = 1'b0;
        rst_n         = 1'b1;
        checks        = 0;
        fails         = 0;
        io.enq_ena    = 1'b0;
        io.enq_v      = '0;
        io.enq_length = '0;
        io.heard_rdy  = 1'b0;
        io.heard2_rdy = 1'b0;
        io.heard3_rdy = 1'b0;
        #1;
        rst_n = 1'b0;
        test_reset();
        test_heard();
        test_backpressure();
        test_back_to_back();
        test_bad();
        test_saturate();
        test_async_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin fails++; $display("FAIL sb_leftover pending=%0d expected 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
